pc_fetch_ctrl: RTL
==================

Name: pc_fetch_ctrl

Overview:
- Fetch-stage sequencer that owns the PC register and feeds PC4 to the next-PC logic.
- Issues instruction-memory requests and absorbs memory wait states and decode stalls with a one-entry skid buffer.
- Applies branch/jump redirects after the delay slot, and exception vectoring.
- Drives the IF/ID register (if_valid, if_instr, if_pc).

Parameters:
RESET_PC, 32'h0000_3000, PC loaded on reset
EXC_VECTOR, 32'h0000_4180, PC loaded on exception

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high
stall  in  1  hazard unit: decode cannot accept a new instruction
redirect_valid  in  1  single-cycle pulse: taken branch/jump resolved in decode
redirect_target  in  32  next-PC value from the next-PC logic
exc_req  in  1  single-cycle pulse: take exception
imem_ready  in  1  imem_rdata valid for address pc this cycle
imem_rdata  in  32  instruction word
imem_req  out  1  fetch request, address = pc
pc  out  32  current fetch address
pc4  out  32  pc + 4, combinational
if_valid  out  1  IF/ID register holds a valid instruction
if_instr  out  32  IF/ID instruction
if_pc  out  32  address of if_instr

Behaviour:
- Reset, async: pc=RESET_PC, if_valid=0, if_instr=0, if_pc=0, imem_req=0, skid empty, pending redirect cleared, state=BOOT.
- States: BOOT, FETCH, WAIT, HOLD.
- BOOT: imem_req=0; unconditionally -> FETCH next cycle.
- FETCH and WAIT: imem_req=1. accept = imem_ready.
  - accept && !stall: if_instr<=imem_rdata, if_pc<=pc, if_valid<=1, pc<=nextpc, -> FETCH.
  - accept && stall: skid<=imem_rdata, skid_pc<=pc, IF/ID held, -> HOLD.
  - !accept: -> WAIT. IF/ID held if stall, else if_valid<=0 (bubble).
- HOLD: imem_req=0, pc held.
  - stall: IF/ID and skid held.
  - !stall: IF/ID<=skid, if_valid<=1, pc<=nextpc, -> FETCH.
- nextpc priority:
  - pending or incoming redirect -> its target, and pending is cleared.
  - otherwise pc+4, 32-bit wrap with no flag.
- Redirect:
  - A pulse not consumed in its own cycle is latched as pending (valid + target).
  - A redirect arriving while one is pending overwrites it; the latest wins.
  - Delay-slot semantics: the instruction fetched at the current pc (the delay slot) always completes; the redirect takes effect on the following advance.
- Exception (any state except BOOT, overrides stall and redirect):
  - Next cycle: pc=EXC_VECTOR, if_valid=0, skid emptied, pending redirect cleared, state FETCH.
  - An in-flight WAIT access is abandoned. Imem is combinational-ready, so the address may change without a protocol violation.
- exc_req in BOOT is ignored.
- Throughput: 1 instruction/cycle with imem_ready=1 and stall=0. IF/ID updates one cycle after accept.

Optional Feature:
PC_ALIGN_CHECK_EN
- With the macro defined:
  - Adds output fetch_adel (1 bit, registered, reset 0).
  - When nextpc would select a redirect target with target[1:0]!=2'b00, pc<=EXC_VECTOR instead, fetch_adel pulses 1 cycle, and the pending redirect is cleared.
- Without the macro: no port; targets are used as-is.

Decomposition:
- Shared package mips_pkg holds:
  - fetch state encoding: BOOT=2'd0, FETCH=2'd1, WAIT=2'd2, HOLD=2'd3;
  - defaults RESET_PC and EXC_VECTOR;
  - the instruction width constant 32.
- One natural sub-module, fetch_skid_buf: one-entry instruction/pc holding register with load/clear.
- Next-PC select, FSM and IF/ID register stay in the top module.

Test Plan:
- Reset release, imem_ready=1, stall=0 -> BOOT for 1 cycle; pc 0x3000,0x3004,0x3008; if_valid=1 from the cycle after the first accept; if_pc lags pc by one.
- redirect_valid with target 0x3100 while pc=0x3008 -> 0x3008 (delay slot) fetched; next pc=0x3100.
- imem_ready low 3 cycles at pc=0x300C with a redirect pulse during WAIT -> pending held; 0x300C delivered; pc then 0x3200.
- stall high when imem_ready=1 at pc=0x3010 -> HOLD, imem_req=0, IF/ID unchanged; stall low -> if_instr=skid word, if_pc=0x3010, pc=0x3014.
- exc_req during HOLD with a redirect pending -> next cycle pc=0x4180, if_valid=0, skid and pending cleared; fetch resumes at 0x4180, 0x4184.
- Async reset asserted mid-WAIT -> outputs return to reset values immediately, without a clock edge. With PC_ALIGN_CHECK_EN, redirect to 0x3102 -> pc=0x4180 and fetch_adel pulses.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared fetch-stage types and constants.
package mips_pkg;

  localparam int unsigned INSTR_W = 32;

  localparam logic [INSTR_W-1:0] RESET_PC_DEFAULT   = 32'h0000_3000;
  localparam logic [INSTR_W-1:0] EXC_VECTOR_DEFAULT = 32'h0000_4180;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } fetch_state_e;

  // Instruction word paired with the address it was fetched from.
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [INSTR_W-1:0] pc;
  } fetch_word_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding register for a fetched word that decode could not take.
module fetch_skid_buf
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        clear,
  input  fetch_word_t d,
  output logic        valid,
  output fetch_word_t q
);

  // Clear wins over load so an exception always empties the buffer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage sequencer: PC register, imem request, skid buffer, IF/ID register.
// Optional macro PC_ALIGN_CHECK_EN adds fetch_adel and vectors misaligned
// redirect targets to the exception address.
module pc_fetch_ctrl
  import mips_pkg::*;
#(
  parameter logic [INSTR_W-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter logic [INSTR_W-1:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [INSTR_W-1:0] redirect_target,
  input  logic               exc_req,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               imem_req,
  output logic [INSTR_W-1:0] pc,
  output logic [INSTR_W-1:0] pc4,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [INSTR_W-1:0] if_pc
`ifdef PC_ALIGN_CHECK_EN
  ,
  output logic               fetch_adel
`endif
);

  fetch_state_e state_q, state_d;

  logic               pend_valid;
  logic [INSTR_W-1:0] pend_target;

  logic               advance;
  logic               take_exc;
  logic               skid_load;
  logic               skid_clear;
  logic               if_load_mem;
  logic               if_load_skid;
  logic               if_bubble;

  logic               redir_sel;
  logic [INSTR_W-1:0] redir_tgt;
  logic [INSTR_W-1:0] nextpc;
  logic               misalign;

  logic               skid_valid;
  fetch_word_t        skid_q;
  fetch_word_t        skid_d;

  assign pc4 = pc + INSTR_W'(4);

  // Next-PC select: an incoming redirect beats a pending one, else sequential.
  always_comb begin
    redir_sel = redirect_valid || pend_valid;
    redir_tgt = redirect_valid ? redirect_target : pend_target;
    nextpc    = redir_sel ? redir_tgt : pc4;
`ifdef PC_ALIGN_CHECK_EN
    misalign  = redir_sel && (redir_tgt[1:0] != 2'b00);
`else
    misalign  = 1'b0;
`endif
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= BOOT;
    else       state_q <= state_d;
  end

  // Next-state and per-cycle control strobes.
  always_comb begin
    state_d      = state_q;
    advance      = 1'b0;
    take_exc     = 1'b0;
    skid_load    = 1'b0;
    skid_clear   = 1'b0;
    if_load_mem  = 1'b0;
    if_load_skid = 1'b0;
    if_bubble    = 1'b0;
    if (exc_req && (state_q != BOOT)) begin
      take_exc   = 1'b1;
      skid_clear = 1'b1;
      state_d    = FETCH;
    end else begin
      case (state_q)
        BOOT: state_d = FETCH;
        FETCH, WAIT: begin
          if (imem_ready && !stall) begin
            if_load_mem = 1'b1;
            advance     = 1'b1;
            state_d     = FETCH;
          end else if (imem_ready) begin
            skid_load = 1'b1;
            state_d   = HOLD;
          end else begin
            if_bubble = !stall;
            state_d   = WAIT;
          end
        end
        HOLD: begin
          if (!stall) begin
            if_load_skid = 1'b1;
            skid_clear   = 1'b1;
            advance      = 1'b1;
            state_d      = FETCH;
          end
        end
        default: state_d = BOOT;
      endcase
    end
  end

  assign skid_d = '{instr: imem_rdata, pc: pc};

  fetch_skid_buf u_skid (
    .clk   (clk),
    .reset (reset),
    .load  (skid_load),
    .clear (skid_clear),
    .d     (skid_d),
    .valid (skid_valid),
    .q     (skid_q)
  );

  // PC register and request strobe; the request follows the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc       <= RESET_PC;
      imem_req <= 1'b0;
    end else begin
      imem_req <= (state_d == FETCH) || (state_d == WAIT);
      if (take_exc)     pc <= EXC_VECTOR;
      else if (advance) pc <= misalign ? EXC_VECTOR : nextpc;
    end
  end

  // Pending redirect: latched when not consumed, latest wins, cleared on use.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_valid  <= 1'b0;
      pend_target <= '0;
    end else if (take_exc || advance) begin
      pend_valid  <= 1'b0;
    end else if (redirect_valid) begin
      pend_valid  <= 1'b1;
      pend_target <= redirect_target;
    end
  end

  // IF/ID register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_valid <= 1'b0;
      if_instr <= '0;
      if_pc    <= '0;
    end else if (take_exc || if_bubble) begin
      if_valid <= 1'b0;
    end else if (if_load_mem) begin
      if_valid <= 1'b1;
      if_instr <= imem_rdata;
      if_pc    <= pc;
    end else if (if_load_skid) begin
      if_valid <= skid_valid;
      if_instr <= skid_q.instr;
      if_pc    <= skid_q.pc;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  // One-cycle flag when a misaligned redirect was replaced by the vector.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) fetch_adel <= 1'b0;
    else       fetch_adel <= advance && misalign;
  end
`endif

endmodule
